// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the multicycle stage sequencer: state encodings, CPU stage codes, opcodes.
package stage_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REGRD  = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WBRES  = 4'd6,
        S_WB     = 4'd7,
        S_PCUPD  = 4'd8,
        S_HALT   = 4'd9
    } seq_state_e;

    // Stage numbering matches the existing datapath's stage counter.
    localparam logic [2:0] STG_FETCH  = 3'b000;
    localparam logic [2:0] STG_DECODE = 3'b001;
    localparam logic [2:0] STG_REGRD  = 3'b010;
    localparam logic [2:0] STG_EXEC   = 3'b011;
    localparam logic [2:0] STG_MEM    = 3'b100;
    localparam logic [2:0] STG_WBRES  = 3'b101;
    localparam logic [2:0] STG_WB     = 3'b110;
    localparam logic [2:0] STG_PCUPD  = 3'b111;

    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BNE  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic [2:0] stage_of(input seq_state_e s);
        case (s)
            S_FETCH:  return STG_FETCH;
            S_DECODE: return STG_DECODE;
            S_REGRD:  return STG_REGRD;
            S_EXEC:   return STG_EXEC;
            S_MEM:    return STG_MEM;
            S_WBRES:  return STG_WBRES;
            S_WB:     return STG_WB;
            S_PCUPD:  return STG_PCUPD;
            default:  return STG_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/strobe bundle between the stage sequencer (slave) and the CPU datapath (master).
// SINGLE_STEP_EN adds the step_i request line.
interface stage_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
`ifdef SINGLE_STEP_EN
    logic             step_i;
`endif
    logic             run_i;
    logic [3:0]       opcode_i;
    logic             mem_r_en_i;
    logic             mem_w_en_i;
    logic             reg_w_en_i;
    logic             mem_ready_i;
    logic             fetch_o;
    logic             decode_o;
    logic             read_regs_o;
    logic             execute_o;
    logic             access_mem_o;
    logic             wb_resolve_o;
    logic             writeback_o;
    logic             update_pc_o;
    logic [2:0]       stage_o;
    logic             busy_o;
    logic             halted_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] instr_count_o;

    modport master (
`ifdef SINGLE_STEP_EN
        output step_i,
`endif
        output run_i, opcode_i, mem_r_en_i, mem_w_en_i, reg_w_en_i, mem_ready_i,
        input  fetch_o, decode_o, read_regs_o, execute_o, access_mem_o, wb_resolve_o,
        input  writeback_o, update_pc_o, stage_o, busy_o, halted_o, mem_err_o, instr_count_o
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        input  step_i,
`endif
        input  run_i, opcode_i, mem_r_en_i, mem_w_en_i, reg_w_en_i, mem_ready_i,
        output fetch_o, decode_o, read_regs_o, execute_o, access_mem_o, wb_resolve_o,
        output writeback_o, update_pc_o, stage_o, busy_o, halted_o, mem_err_o, instr_count_o
    );

endinterface

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Data-memory wait timer: down-counter reloaded while load_i is high, terminal count at zero.
module stage_sequencer_mem_wait_timer #(
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  LOAD = 8'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Registered multicycle stage sequencer for the 8-bit CPU datapath (Moore strobes per stage).
// SINGLE_STEP_EN: adds bus.step_i, letting IDLE launch a single instruction while run_i is low.
//
//  state   | meaning
//  IDLE    | waiting for run (or step)
//  FETCH   | latch instruction_data
//  DECODE  | control unit decode
//  REGRD   | read register file / jump offset; HALT opcode diverts here
//  EXEC    | ALU evaluate
//  MEM     | data memory access, waits on mem_ready with timeout
//  WBRES   | select ALU vs memory result
//  WB      | register file write
//  PCUPD   | program counter update, retire instruction
//  HALT    | absorbing stop; only rst leaves
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [3:0]  HALT_OPCODE = OP_HALT,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    stage_sequencer_if.slave bus
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_err_q, mem_err_d;
    logic             in_mem_q;
    logic             tmr_load, tmr_en, tmr_tc;
    logic             start;

`ifdef SINGLE_STEP_EN
    assign start = bus.run_i | bus.step_i;
`else
    assign start = bus.run_i;
`endif

    stage_sequencer_mem_wait_timer #(
        .W    (8),
        .LOAD (8'(MEM_TIMEOUT))
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mem_err_q <= 1'b0;
            in_mem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mem_err_q <= mem_err_d;
            in_mem_q  <= (state_q == S_MEM);
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_err_d = mem_err_q;
        tmr_load  = 1'b1;
        tmr_en    = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_REGRD;
            S_REGRD:  state_d = (bus.opcode_i == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (bus.mem_r_en_i | bus.mem_w_en_i) ? S_MEM : S_WBRES;
            S_MEM: begin
                tmr_load = 1'b0;
                // Ready is checked before the timeout so a late ready still completes.
                if (bus.mem_ready_i) begin
                    state_d = S_WBRES;
                end else if (tmr_tc) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_WBRES:  state_d = bus.reg_w_en_i ? S_WB : S_PCUPD;
            S_WB:     state_d = S_PCUPD;
            S_PCUPD: begin
                count_d = count_q + CNT_W'(1);
                state_d = bus.run_i ? S_FETCH : S_IDLE;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.fetch_o       = (state_q == S_FETCH);
    assign bus.decode_o      = (state_q == S_DECODE);
    assign bus.read_regs_o   = (state_q == S_REGRD);
    assign bus.execute_o     = (state_q == S_EXEC);
    assign bus.access_mem_o  = (state_q == S_MEM) && !in_mem_q;
    assign bus.wb_resolve_o  = (state_q == S_WBRES);
    assign bus.writeback_o   = (state_q == S_WB);
    assign bus.update_pc_o   = (state_q == S_PCUPD);
    assign bus.stage_o       = stage_of(state_q);
    assign bus.busy_o        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted_o      = (state_q == S_HALT);
    assign bus.mem_err_o     = mem_err_q;
    assign bus.instr_count_o = count_q;

endmodule
